trdb_encap_buffer: RTL
======================

TRDB_ENCAP_BUFFER -- requirements
Module: trdb_encap_buffer

Interface
REQ-001 SHALL have parameter PKT_W, default 64, packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter LOW_WM, default 4, level at or below which a stalled buffer re-asserts ready; LOW_WM < DEPTH.
REQ-004 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous FIFO clear.
REQ-007 SHALL have port pkt_valid_i  input  1  packet from emitter valid this cycle.
REQ-008 SHALL have port pkt_data_i  input  PKT_W  packet payload.
REQ-009 SHALL have port encapsulator_ready_o  output  1  ready level sent to encoder control; encoder edge-detects it (rise = trace on, fall = trace off).
REQ-010 SHALL have port out_valid_o  output  1  head entry valid toward encapsulator datapath.
REQ-011 SHALL have port out_data_o  output  PKT_W  head entry payload.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts head.
REQ-013 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow_o  output  1  one-cycle pulse per dropped packet.
REQ-015 SHALL have port drop_cnt_o  output  16  dropped-packet count; present only per REQ-031.

Function
REQ-016 SHALL write pkt_data_i at tail when pkt_valid_i=1 and level<DEPTH, evaluated on the pre-update level.
REQ-017 SHALL reject the write when level=DEPTH, even if a read happens in the same cycle.
REQ-018 SHALL pop head when out_valid_o=1 and out_ready_i=1.
REQ-019 SHALL drive out_valid_o = (level!=0), with out_data_o = head entry, first-word-fall-through: packet written in cycle N visible at outputs in cycle N+1.
REQ-020 SHALL on simultaneous accepted write and pop keep level unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-021 SHALL keep out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL implement ready FSM, states INIT, READY, STALL; encapsulator_ready_o registered: 0 in INIT and STALL, 1 in READY.
REQ-023 SHALL transition INIT->READY unconditionally one cycle after reset release, producing a rising edge for the encoder.
REQ-024 SHALL transition READY->STALL when post-update level = DEPTH; encapsulator_ready_o falls in the following cycle.
REQ-025 SHALL transition STALL->READY when post-update level <= LOW_WM.
REQ-026 SHALL on a rejected write assert overflow_o for exactly the next cycle; FSM state is unaffected.
REQ-027 SHALL on flush_i=1 set level to 0, reset pointers, discard any same-cycle write and pop, set FSM to READY from STALL, and leave INIT to proceed per REQ-023; flush takes priority over all other events.

Reset
REQ-028 SHALL on rst_ni=0 asynchronously clear pointers and level, set FSM to INIT, encapsulator_ready_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0.
REQ-029 SHALL not reset FIFO storage contents; out_data_o is don't-care while out_valid_o=0.
REQ-030 SHALL on reset asserted mid-operation discard all buffered packets with no further output.

Configuration
REQ-031 SHALL, with TRDB_DROP_CNT_EN defined, include drop_cnt_o, incremented by 1 per rejected write, saturating at 16'hFFFF, cleared only by reset (not by flush_i).
REQ-032 SHALL, without TRDB_DROP_CNT_EN, omit the drop_cnt_o port and its counter; overflow_o remains.

Verification
REQ-033 SHALL test reset release: encapsulator_ready_o 0 in first cycle, then 1 in second cycle and held; level_o=0.
REQ-034 SHALL test 8 writes with out_ready_i=0 (DEPTH=8): level_o=8, ready falls the cycle after the 8th write; 9th write -> overflow_o pulse, drop_cnt_o=1.
REQ-035 SHALL test draining from full with out_ready_i=1: data out in write order; ready re-rises the cycle after level_o reaches 4.
REQ-036 SHALL test simultaneous write and pop at level 3 for 10 cycles: level_o stays 3, order preserved across pointer wrap.
REQ-037 SHALL test flush_i with pkt_valid_i=1 at level 8 in STALL: next cycle level_o=0, out_valid_o=0, encapsulator_ready_o=1, drop_cnt_o unchanged.
REQ-038 SHALL test 70000 rejected writes under TRDB_DROP_CNT_EN: drop_cnt_o saturates at 65535.

Source files
------------

// File: rtl/trdb_encap_buffer.sv
// Trace packet buffer between the emitter and the encapsulator: FWFT FIFO plus a
// ready FSM with watermark hysteresis. Define TRDB_DROP_CNT_EN to add drop_cnt_o.
module trdb_encap_buffer #(
    parameter int PKT_W  = 64,
    parameter int DEPTH  = 8,
    parameter int LOW_WM = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     pkt_valid_i,
    input  logic [PKT_W-1:0]         pkt_data_i,
    output logic                     encapsulator_ready_o,
    output logic                     out_valid_o,
    output logic [PKT_W-1:0]         out_data_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
`ifdef TRDB_DROP_CNT_EN
    output logic [15:0]              drop_cnt_o,
`endif
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {INIT, READY, STALL} state_e;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q, level_nxt;
    logic             full, wr_en, rd_en, rejected;
    state_e           state_q;

    assign full        = (level_q == LW'(DEPTH));
    assign out_valid_o = (level_q != '0);
    assign out_data_o  = mem[rd_ptr];
    assign level_o     = level_q;

    // Flush wins over everything: no write, no pop, and no drop is recorded.
    assign wr_en    = pkt_valid_i && !full && !flush_i;
    assign rd_en    = out_valid_o && out_ready_i && !flush_i;
    assign rejected = pkt_valid_i && full && !flush_i;

    always_comb begin
        level_nxt = level_q + LW'(wr_en) - LW'(rd_en);
        if (flush_i) level_nxt = '0;
    end

    // Storage carries no reset; stale entries are never visible while level is 0.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= pkt_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= rejected;
            level_q    <= level_nxt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Ready FSM decides on the post-update level so the encoder sees the edge
    // in the cycle right after the level crosses a threshold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= INIT;
            encapsulator_ready_o <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q              <= READY;
                    encapsulator_ready_o <= 1'b1;
                end
                READY: begin
                    if (level_nxt == LW'(DEPTH)) begin
                        state_q              <= STALL;
                        encapsulator_ready_o <= 1'b0;
                    end
                end
                STALL: begin
                    if (level_nxt <= LW'(LOW_WM)) begin
                        state_q              <= READY;
                        encapsulator_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q              <= INIT;
                    encapsulator_ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRDB_DROP_CNT_EN
    // Saturating drop counter; survives flush, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_o <= '0;
        else if (rejected && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`endif

endmodule
